// File: rtl/mul_add_int.sv
// mul_add_int: iterative unsigned shift-add multiply-accumulate, x = q*y + r.
// Rebuilds a dividend from quotient, divisor and remainder. It uses the same
// start/busy/valid handshake as the integer divider. The latency is fixed at
// WIDTH iterations, and there is no early exit.
//
// Ports
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   start  1-cycle request; samples q, y, r (restarts if already busy)
//   busy   computation in progress
//   valid  1-cycle pulse; x and rerr are valid
//   rerr   remainder error: r >= y at start (includes y == 0)
//   q      multiplier (quotient), WIDTH bits
//   y      multiplicand (divisor), WIDTH bits
//   r      addend (remainder), WIDTH bits
//   x      result q*y + r, 2*WIDTH bits; holds until next completion or reset
module mul_add_int #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  output logic                 rerr,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     y,
  input  logic [WIDTH-1:0]     r,
  output logic [2*WIDTH-1:0]   x
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   y1;
  logic [WIDTH-1:0]   mq;
  logic [CW-1:0]      i;
  logic               rerr_int;

  // One adder: the partial product for bit i is y1 shifted into place.
  // The worst-case sum (2^W-1)^2 + 2^W-1 still fits in 2*WIDTH bits.
  always_comb begin
    addend  = '0;
    if (mq[0]) begin
      addend = {{WIDTH{1'b0}}, y1} << i;
    end
    acc_sum = acc + addend;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      valid    <= 1'b0;
      rerr     <= 1'b0;
      x        <= '0;
      acc      <= '0;
      y1       <= '0;
      mq       <= '0;
      i        <= '0;
      rerr_int <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        // Start wins over iteration. A start while busy silently drops the old job.
        y1       <= y;
        mq       <= q;
        acc      <= {{WIDTH{1'b0}}, r};
        i        <= '0;
        busy     <= 1'b1;
        rerr_int <= (r >= y);
      end else if (busy) begin
        acc <= acc_sum;
        mq  <= mq >> 1;
        if (i == LAST) begin
          busy  <= 1'b0;
          valid <= 1'b1;
          x     <= acc_sum;
          rerr  <= rerr_int;
        end else begin
          i <= i + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_add_int.sv
module tb_mul_add_int;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  // WIDTH = 8 instance
  logic        start;
  logic        busy, valid, rerr;
  logic [7:0]  q, y, r;
  logic [15:0] x;

  // WIDTH = 2 instance
  logic        start2;
  logic        busy2, valid2, rerr2;
  logic [1:0]  q2, y2, r2;
  logic [3:0]  x2;

  // WIDTH = 16 instance
  logic        start16;
  logic        busy16, valid16, rerr16;
  logic [15:0] q16, y16, r16;
  logic [31:0] x16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_add_int #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .valid(valid),
    .rerr(rerr), .q(q), .y(y), .r(r), .x(x));

  mul_add_int #(.WIDTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .busy(busy2), .valid(valid2),
    .rerr(rerr2), .q(q2), .y(y2), .r(r2), .x(x2));

  mul_add_int #(.WIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .busy(busy16), .valid(valid16),
    .rerr(rerr16), .q(q16), .y(y16), .r(r16), .x(x16));

  // Stimulus helpers: these only drive inputs and count edges. All comparisons are made in the test tasks.
  // The caller must be #1 after a rising edge. This task returns #1 after edge 0.
  task automatic do_start(input logic [7:0] qv, input logic [7:0] yv, input logic [7:0] rv);
    q = qv; y = yv; r = rv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts the edges after edge 0 until valid is seen, with a bound of 40.
  task automatic wait_valid(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || rerr !== 1'b0 || x !== 16'd0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b rerr=%b x=%0d want 0 0 0 0", busy, valid, rerr, x);
    end
  endtask

  task automatic test_basic;
    int e, b;
    do_start(8'd13, 8'd7, 8'd5);
    wait_valid(e, b);
    checks++;
    if (e !== 8) begin errors++; $display("FAIL basic_latency: edges=%0d want 8", e); end
    checks++;
    if (b !== 8) begin errors++; $display("FAIL basic_busy: busy_cycles=%0d want 8", b); end
    checks++;
    if (x !== 16'd96 || rerr !== 1'b0) begin
      errors++; $display("FAIL basic_result: x=%0d rerr=%b want 96 0", x, rerr);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || x !== 16'd96) begin
      errors++; $display("FAIL basic_pulse: valid=%b x=%0d want 0 96", valid, x);
    end
  endtask

  task automatic test_max;
    int e, b;
    do_start(8'd255, 8'd255, 8'd254);
    wait_valid(e, b);
    checks++;
    if (e !== 8 || x !== 16'd65279 || rerr !== 1'b0) begin
      errors++; $display("FAIL max: edges=%0d x=%0d rerr=%b want 8 65279 0", e, x, rerr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rerr;
    int e, b;
    do_start(8'd200, 8'd0, 8'd9);
    wait_valid(e, b);
    checks++;
    if (e !== 8 || x !== 16'd9 || rerr !== 1'b1) begin
      errors++; $display("FAIL y_zero: edges=%0d x=%0d rerr=%b want 8 9 1", e, x, rerr);
    end
    @(posedge clk); #1;
    do_start(8'd3, 8'd4, 8'd4);
    wait_valid(e, b);
    checks++;
    if (e !== 8 || x !== 16'd16 || rerr !== 1'b1) begin
      errors++; $display("FAIL r_eq_y: edges=%0d x=%0d rerr=%b want 8 16 1", e, x, rerr);
    end
    @(posedge clk); #1;
    do_start(8'd0, 8'd50, 8'd17);
    wait_valid(e, b);
    checks++;
    if (e !== 8 || x !== 16'd17 || rerr !== 1'b0) begin
      errors++; $display("FAIL q_zero: edges=%0d x=%0d rerr=%b want 8 17 0", e, x, rerr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_restart;
    int e, b;
    do_start(8'd10, 8'd10, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_start(8'd2, 8'd3, 8'd1);
    wait_valid(e, b);
    checks++;
    if (e !== 8 || x !== 16'd7 || rerr !== 1'b0) begin
      errors++; $display("FAIL restart: edges=%0d x=%0d rerr=%b want 8 7 0", e, x, rerr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int seen = 0;
    do_start(8'd9, 8'd9, 8'd3);
    repeat (3) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || rerr !== 1'b0 || x !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b rerr=%b x=%0d want 0 0 0 0", busy, valid, rerr, x);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_valid: active_cycles=%0d want 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] qv [6];
    logic [7:0] yv [6];
    logic [7:0] rv [6];
    int e, b;
    qv[0] = 8'd1;   yv[0] = 8'd1;   rv[0] = 8'd0;
    qv[1] = 8'd128; yv[1] = 8'd2;   rv[1] = 8'd1;
    qv[2] = 8'd85;  yv[2] = 8'd170; rv[2] = 8'd200;
    for (int k = 3; k < 6; k++) begin
      qv[k] = 8'($urandom_range(255));
      yv[k] = 8'($urandom_range(255));
      rv[k] = 8'($urandom_range(255));
    end
    do_start(qv[0], yv[0], rv[0]);
    for (int k = 0; k < 6; k++) begin
      wait_valid(e, b);
      checks++;
      if (e !== 8 || x !== 16'(qv[k]) * 16'(yv[k]) + 16'(rv[k]) || rerr !== (rv[k] >= yv[k])) begin
        errors++;
        $display("FAIL b2b[%0d]: edges=%0d x=%0d rerr=%b want 8 %0d %b", k, e, x, rerr,
                 16'(qv[k]) * 16'(yv[k]) + 16'(rv[k]), rv[k] >= yv[k]);
      end
      if (k < 5) do_start(qv[k+1], yv[k+1], rv[k+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width2;
    logic [1:0] tq [2] = '{2'd3, 2'd2};
    logic [1:0] ty [2] = '{2'd3, 2'd1};
    logic [1:0] tr [2] = '{2'd2, 2'd1};
    logic [3:0] tx [2] = '{4'd11, 4'd3};
    logic       te [2] = '{1'b0, 1'b1};
    int e;
    for (int k = 0; k < 2; k++) begin
      q2 = tq[k]; y2 = ty[k]; r2 = tr[k]; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      e = 0;
      while (!valid2 && e < 20) begin @(posedge clk); #1; e++; end
      checks++;
      if (e !== 2 || x2 !== tx[k] || rerr2 !== te[k]) begin
        errors++;
        $display("FAIL w2[%0d]: edges=%0d x=%0d rerr=%b want 2 %0d %b", k, e, x2, rerr2, tx[k], te[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width16;
    logic [15:0] tq [2] = '{16'd65535, 16'd1000};
    logic [15:0] ty [2] = '{16'd65535, 16'd300};
    logic [15:0] tr [2] = '{16'd65534, 16'd299};
    logic [31:0] tx [2] = '{32'd4294901759, 32'd300299};
    int e;
    for (int k = 0; k < 2; k++) begin
      q16 = tq[k]; y16 = ty[k]; r16 = tr[k]; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      e = 0;
      while (!valid16 && e < 40) begin @(posedge clk); #1; e++; end
      checks++;
      if (e !== 16 || x16 !== tx[k] || rerr16 !== 1'b0) begin
        errors++;
        $display("FAIL w16[%0d]: edges=%0d x=%0d rerr=%b want 16 %0d 0", k, e, x16, rerr16, tx[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    start = 1'b0; q = '0; y = '0; r = '0;
    start2 = 1'b0; q2 = '0; y2 = '0; r2 = '0;
    start16 = 1'b0; q16 = '0; y16 = '0; r16 = '0;
    #12;
    test_reset;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_max;
    test_rerr;
    test_restart;
    test_async_reset;
    test_back_to_back;
    test_width2;
    test_width16;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
